// File: rtl/gradient_ci_pkg.sv
// Shared definitions for the gradient custom-instruction master: FSM encoding
// and the bit positions of the per-quad flags returned in ci_result.
package gradient_ci_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam int DX_BIT = 0;
    localparam int DY_BIT = 1;

    // Adds a single flag bit to a 16-bit tally.
    function automatic logic [15:0] add_flag(input logic [15:0] tally, input logic flag);
        return tally + {15'd0, flag};
    endfunction

endpackage

// File: rtl/gradient_ci_master_watchdog.sv
// Wait-cycle watchdog for an outstanding custom instruction. It only exists in
// builds with GRADIENT_CI_TIMEOUT_EN defined, the only builds that instantiate it.
`ifdef GRADIENT_CI_TIMEOUT_EN
module ci_watchdog (
    input  logic        clock,
    input  logic        reset,
    input  logic        arm,
    input  logic        clear,
    input  logic [15:0] limit,
    output logic        expired
);

    logic [15:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 16'd0;
        end else if (clear) begin
            count <= 16'd0;
        end else if (arm) begin
            count <= count + 16'd1;
        end
    end

    // Flags the last armed cycle of the window, so the owner can leave on the next edge.
    assign expired = arm && ((count + 16'd1) >= limit);

endmodule
`endif

// File: rtl/gradient_ci_master.sv
// Streams pixel quads through a custom instruction and tallies the returned
// horizontal/vertical gradient flags. Optional watchdog: GRADIENT_CI_TIMEOUT_EN.
import gradient_ci_pkg::*;

module gradient_ci_master #(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter int         TIMEOUT_CYCLES      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [15:0] cmd_count,
    input  logic        quad_valid,
    input  logic [31:0] quad_data,
    output logic        quad_ready,
    output logic        ci_start,
    output logic [7:0]  ci_n,
    output logic [31:0] ci_value_a,
    output logic [31:0] ci_value_b,
    input  logic        ci_done,
    input  logic [31:0] ci_result,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] dx_count,
    output logic [15:0] dy_count,
    output logic [2:0]  dbg_state
);

    // Quad handshake: a quad transfers on a rising edge where quad_valid and
    // quad_ready are both high; quad_ready is high only in FETCH. CI handshake:
    // ci_start pulses once per operation, ci_done completes it (even in the
    // ci_start cycle) and operands stay frozen until then.

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state;
    logic [15:0] count_q;
    logic [15:0] index;
    logic [15:0] next_index;
    logic        wd_expired;
    logic        unused_result_bits;

    assign next_index         = index + 16'd1;
    assign dbg_state          = state;
    assign unused_result_bits = ^ci_result[31:2];

`ifdef GRADIENT_CI_TIMEOUT_EN
    logic wd_arm;
    logic wd_clear;

    assign wd_arm   = (state == ISSUE) || (state == WAIT);
    assign wd_clear = (state == FETCH);

    ci_watchdog u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .arm     (wd_arm),
        .clear   (wd_clear),
        .limit   (TIMEOUT_LIMIT),
        .expired (wd_expired)
    );
`else
    logic unused_timeout_cfg;

    assign wd_expired         = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_LIMIT;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count_q    <= 16'd0;
            index      <= 16'd0;
            quad_ready <= 1'b0;
            ci_start   <= 1'b0;
            ci_n       <= 8'd0;
            ci_value_a <= 32'd0;
            ci_value_b <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            dx_count   <= 16'd0;
            dy_count   <= 16'd0;
        end else begin
            ci_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        count_q  <= cmd_count;
                        index    <= 16'd0;
                        dx_count <= 16'd0;
                        dy_count <= 16'd0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        if (cmd_count == 16'd0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            quad_ready <= 1'b1;
                        end
                    end
                end

                FETCH: begin
                    if (quad_valid && quad_ready) begin
                        ci_value_a <= quad_data;
                        ci_value_b <= {16'd0, index};
                        ci_n       <= customInstructionId;
                        ci_start   <= 1'b1;
                        quad_ready <= 1'b0;
                        state      <= ISSUE;
                    end
                end

                ISSUE, WAIT: begin
                    if (ci_done) begin
                        dx_count <= add_flag(dx_count, ci_result[DX_BIT]);
                        dy_count <= add_flag(dy_count, ci_result[DY_BIT]);
                        index    <= next_index;
                        if (next_index == count_q) begin
                            state      <= FINISH;
                            done       <= 1'b1;
                            ci_n       <= 8'd0;
                            ci_value_a <= 32'd0;
                            ci_value_b <= 32'd0;
                        end else begin
                            state      <= FETCH;
                            quad_ready <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        // Abandon the silent CI but keep the tallies gathered so far.
                        error      <= 1'b1;
                        state      <= FINISH;
                        done       <= 1'b1;
                        ci_n       <= 8'd0;
                        ci_value_a <= 32'd0;
                        ci_value_b <= 32'd0;
                    end else begin
                        state <= WAIT;
                    end
                end

                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    quad_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gradient_ci_master.sv
// Randomized scoreboard bench for gradient_ci_master: a behavioural CI responder
// and a gradient model predict every issued operation and every completion.
module tb_gradient_ci_master;
  import gradient_ci_pkg::*;

  localparam logic [7:0] CI_ID = 8'h5A;

  logic        clock;
  logic        reset;
  logic        cmd_start;
  logic [15:0] cmd_count;
  logic        quad_valid;
  logic [31:0] quad_data;
  logic        quad_ready;
  logic        ci_start;
  logic [7:0]  ci_n;
  logic [31:0] ci_value_a;
  logic [31:0] ci_value_b;
  logic        ci_done;
  logic [31:0] ci_result;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] dx_count;
  logic [15:0] dy_count;
  logic [2:0]  dbg_state;

  gradient_ci_master #(
    .customInstructionId (CI_ID),
    .TIMEOUT_CYCLES      (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_start  (cmd_start),
    .cmd_count  (cmd_count),
    .quad_valid (quad_valid),
    .quad_data  (quad_data),
    .quad_ready (quad_ready),
    .ci_start   (ci_start),
    .ci_n       (ci_n),
    .ci_value_a (ci_value_a),
    .ci_value_b (ci_value_b),
    .ci_done    (ci_done),
    .ci_result  (ci_result),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .dx_count   (dx_count),
    .dy_count   (dy_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL sim_timeout: simulation did not finish in time");
    $fatal(1, "simulation time limit");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  logic [71:0] exp_q[$];       // {ci_n, ci_value_a, ci_value_b} per issued CI
  logic [32:0] exp_done_q[$];  // {error, dx_count, dy_count} per command
  logic [31:0] cmd_quads[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rule for the responder: a quad flags dx when left/right differ by
  // more than 15 gray levels, dy when up/down differ by more than 15.
  function automatic logic [1:0] grad_bits(input logic [31:0] q);
    int l, r, u, d, gx, gy;
    l = int'(q[7:0]);
    r = int'(q[15:8]);
    u = int'(q[23:16]);
    d = int'(q[31:24]);
    gx = (r > l) ? r - l : l - r;
    gy = (d > u) ? d - u : u - d;
    return {gy > 15, gx > 15};
  endfunction

  // ---------------- CI responder ----------------
  int          resp_mode = 0;  // 0: combinational, 1: fixed latency, 2: silent
  int          latency = 1;
  logic        lat_done = 1'b0;
  logic [31:0] lat_result = 32'd0;
  logic [29:0] noise = 30'd0;
  logic        pending = 1'b0;
  int          pend_cnt = 0;

  assign ci_done   = (resp_mode == 0) ? ci_start : lat_done;
  assign ci_result = (resp_mode == 0) ? {noise, grad_bits(ci_value_a)} : lat_result;

  always begin
    @(posedge clock);
    #1;
    noise = 30'($urandom);
    lat_done = 1'b0;
    if (resp_mode == 1) begin
      if (ci_start) begin
        pending = 1'b1;
        pend_cnt = 1;
      end else if (pending) begin
        pend_cnt++;
      end
      if (pending && pend_cnt >= latency) begin
        lat_done = 1'b1;
        lat_result = {noise, grad_bits(ci_value_a)};
        pending = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        outstanding = 1'b0;
  logic [71:0] out_exp = 72'd0;

  always @(negedge clock) begin
    if (reset) begin
      outstanding = 1'b0;
    end else begin
      if (ci_start) begin
        start_cnt++;
        if (exp_q.size() == 0) begin
          check("ci_start_unexpected", 1, 0);
        end else begin
          out_exp = exp_q.pop_front();
          check("ci_issue", {quad_ready, ci_n, ci_value_a, ci_value_b}, {1'b0, out_exp});
        end
        outstanding = 1'b1;
      end else if (outstanding && busy && !done) begin
        check("ci_hold", {quad_ready, ci_n, ci_value_a, ci_value_b}, {1'b0, out_exp});
      end
      if (outstanding && (ci_done || done || !busy)) outstanding = 1'b0;

      if (done) begin
        done_cnt++;
        check("finish_zero", {ci_n, ci_value_a, ci_value_b}, 0);
        if (exp_done_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          check("done_counts", {error, dx_count, dy_count}, exp_done_q.pop_front());
        end
      end

      if (!busy) begin
        check("idle_zero", {ci_start, ci_n, ci_value_a, ci_value_b, quad_ready, done}, 0);
        check("idle_state", dbg_state, IDLE);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_quad(input logic [31:0] q, input int idx);
    int n;
    quad_valid = 1'b1;
    quad_data = q;
    n = 0;
    while (!quad_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("quad_accept_bound", n >= 200, 0);
    exp_q.push_back({CI_ID, q, 16'd0, 16'(idx)});
    @(negedge clock);
    quad_valid = 1'b0;
    quad_data = $urandom;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clock);
      n++;
    end
    check("cmd_completes", busy, 0);
    check("sb_drained", {exp_q.size(), exp_done_q.size()}, 0);
  endtask

  task automatic build_random(input int n);
    int base;
    cmd_quads.delete();
    for (int i = 0; i < n; i++) begin
      base = $urandom_range(150, 60);
      cmd_quads.push_back({8'(base + $urandom_range(31, 0)), 8'(base + $urandom_range(31, 0)),
                           8'(base + $urandom_range(31, 0)), 8'(base + $urandom_range(31, 0))});
    end
  endtask

  task automatic run_cmd(input int mode, input int lat, input int gap_max, input int withhold);
    int ex, ey, n;
    logic [1:0] g;
    n = cmd_quads.size();
    ex = 0;
    ey = 0;
    foreach (cmd_quads[i]) begin
      g = grad_bits(cmd_quads[i]);
      ex += int'(g[0]);
      ey += int'(g[1]);
    end
    resp_mode = mode;
    latency = lat;
    exp_done_q.push_back({1'b0, 16'(ex), 16'(ey)});
    cmd_count = 16'(n);
    cmd_start = 1'b1;
    @(negedge clock);
    cmd_start = 1'b0;
    for (int w = 0; w < withhold; w++) begin
      check("no_issue_while_starved", ci_start, 0);
      cmd_start = (w == 1);  // stray start while busy must be ignored
      cmd_count = 16'd7;
      @(negedge clock);
      cmd_start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_max, 0)) @(negedge clock);
      send_quad(cmd_quads[i], i);
    end
    wait_idle(400);
  endtask

  // ---------------- main sequence ----------------
  int s0, d0, n;

  initial begin
    reset = 1'b1;
    cmd_start = 1'b0;
    cmd_count = 16'd0;
    quad_valid = 1'b0;
    quad_data = 32'd0;
    repeat (3) @(negedge clock);
    check("reset_outputs", {ci_start, ci_n, ci_value_a, ci_value_b, quad_ready, busy, done,
                            error, dx_count, dy_count}, 0);
    reset = 1'b0;
    @(negedge clock);

    // Fixed quads against a zero-latency responder.
    cmd_quads.delete();
    cmd_quads.push_back(32'h0000_0A00);
    cmd_quads.push_back(32'h0000_1400);
    cmd_quads.push_back(32'h1E00_0000);
    s0 = start_cnt;
    d0 = done_cnt;
    run_cmd(0, 1, 0, 0);
    check("comb_starts", start_cnt - s0, 3);
    check("comb_done_once", done_cnt - d0, 1);
    check("comb_dx", dx_count, 1);
    check("comb_dy", dy_count, 1);
    repeat (3) @(negedge clock);
    check("counts_hold_after_done", {dx_count, dy_count}, {16'd1, 16'd1});

    // Four-cycle responder, two quads.
    build_random(2);
    s0 = start_cnt;
    run_cmd(1, 4, 0, 0);
    check("lat4_starts", start_cnt - s0, 2);

    // Empty command: done in the cycle after the start cycle, nothing issued.
    s0 = start_cnt;
    exp_done_q.push_back(33'd0);
    cmd_count = 16'd0;
    cmd_start = 1'b1;
    @(negedge clock);
    cmd_start = 1'b0;
    check("zero_cmd_done", {done, busy}, 2'b11);
    @(negedge clock);
    check("zero_cmd_idle", {done, busy}, 2'b00);
    check("zero_cmd_no_ci", start_cnt - s0, 0);
    check("zero_cmd_counts", {error, dx_count, dy_count}, 0);

    // Starved FETCH plus a stray cmd_start while busy.
    build_random(1);
    s0 = start_cnt;
    run_cmd(1, 2, 0, 5);
    check("starved_starts", start_cnt - s0, 1);

    // Silent responder.
    build_random(1);
    resp_mode = 2;
`ifdef GRADIENT_CI_TIMEOUT_EN
    exp_done_q.push_back({1'b1, 16'd0, 16'd0});
`endif
    cmd_count = 16'd1;
    cmd_start = 1'b1;
    @(negedge clock);
    cmd_start = 1'b0;
    send_quad(cmd_quads[0], 0);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
    end
`ifdef GRADIENT_CI_TIMEOUT_EN
    check("timeout_latency", n, 16);
    check("timeout_error", error, 1);
    wait_idle(10);
`else
    check("no_watchdog_busy", {done, busy}, 2'b01);
    reset = 1'b1;
    #1;
    exp_q.delete();
    exp_done_q.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
`endif

    // Reset while a CI is outstanding, then a late ci_done in IDLE.
    build_random(1);
    resp_mode = 1;
    latency = 10;
    exp_done_q.push_back(33'd0);
    cmd_count = 16'd1;
    cmd_start = 1'b1;
    @(negedge clock);
    cmd_start = 1'b0;
    send_quad(cmd_quads[0], 0);
    repeat (3) @(negedge clock);
    check("wait_before_reset", busy, 1);
    reset = 1'b1;
    #1;
    check("reset_mid_wait", {ci_start, ci_n, ci_value_a, ci_value_b, quad_ready, busy, done,
                             error, dx_count, dy_count}, 0);
    exp_q.delete();
    exp_done_q.delete();
    @(negedge clock);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (15) @(negedge clock);
    check("late_done_ignored", {busy, dx_count, dy_count}, 0);
    check("late_done_no_pulse", done_cnt - d0, 0);
    build_random(3);
    run_cmd(0, 1, 2, 0);

    // Randomized commands.
    for (int c = 0; c < 10; c++) begin
      build_random($urandom_range(6, 1));
      run_cmd($urandom_range(1, 0), $urandom_range(5, 1), $urandom_range(3, 0), 0);
      repeat ($urandom_range(3, 0)) @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
